// File: rtl/sdr_fetch_cache_if.sv
// CPU-side read port and SDRAM read channel of the direct-mapped fetch cache.
interface sdr_fetch_cache_if;
    logic        cpu_cs;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_ok;
    logic        flush;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_rdy;
    logic [15:0] sdr_dout;

    modport slave (
        input  cpu_cs, cpu_addr, flush, sdr_rdy, sdr_dout,
        output cpu_dout, cpu_ok, sdr_addr, sdr_req
    );

    modport master (
        output cpu_cs, cpu_addr, flush, sdr_rdy, sdr_dout,
        input  cpu_dout, cpu_ok, sdr_addr, sdr_req
    );
endinterface

// File: rtl/sdr_fetch_cache.sv
// Direct-mapped read cache, one 16-bit SDRAM word per line, byte-wide CPU port.
module sdr_fetch_cache #(
    parameter int          INDEX_BITS = 6,
    parameter logic [24:0] ADDR_BASE  = 25'h0
) (
    input  logic             clk,
    input  logic             reset,
    sdr_fetch_cache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 16 - INDEX_BITS;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] FILL   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [16:0]      addr_q, addr_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic             flushed_q, flushed_d;
    logic             sdr_req_q, sdr_req_d;
    logic [24:0]      sdr_addr_q, sdr_addr_d;
    logic             cpu_ok_q, cpu_ok_d;
    logic [7:0]       cpu_dout_q, cpu_dout_d;
    logic             wr_en;

    logic [15:0]      data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic [24:0]           fill_addr;

    assign idx       = addr_q[INDEX_BITS:1];
    assign tag       = addr_q[16:INDEX_BITS+1];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign fill_addr = ADDR_BASE + {8'd0, addr_q[16:1], 1'b0};

    function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        flushed_d  = flushed_q;
        sdr_req_d  = sdr_req_q;
        sdr_addr_d = sdr_addr_q;
        cpu_ok_d   = cpu_ok_q;
        cpu_dout_d = cpu_dout_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (bus.cpu_cs) begin
                    addr_d  = bus.cpu_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.flush) begin
                    valid_d = '0;
                    state_d = IDLE;
                end else if (hit) begin
                    cpu_ok_d   = 1'b1;
                    cpu_dout_d = pick(data_q[idx], addr_q[0]);
                    state_d    = DONE;
                end else begin
                    sdr_addr_d = fill_addr & ~25'h1;
                    sdr_req_d  = 1'b1;
                    flushed_d  = 1'b0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                // A flush seen at any point of the fill poisons the returned word.
                if (bus.flush) begin
                    valid_d   = '0;
                    flushed_d = 1'b1;
                end
                if (bus.sdr_rdy) begin
                    sdr_req_d = 1'b0;
                    if (bus.flush || flushed_q) begin
                        state_d = IDLE;
                    end else begin
                        wr_en        = 1'b1;
                        valid_d[idx] = 1'b1;
                        cpu_ok_d     = 1'b1;
                        cpu_dout_d   = pick(bus.sdr_dout, addr_q[0]);
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.flush) begin
                    valid_d  = '0;
                    cpu_ok_d = 1'b0;
                    state_d  = IDLE;
                end else if (!bus.cpu_cs || (bus.cpu_addr != addr_q)) begin
                    cpu_ok_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            valid_q    <= '0;
            flushed_q  <= 1'b0;
            sdr_req_q  <= 1'b0;
            sdr_addr_q <= '0;
            cpu_ok_q   <= 1'b0;
            cpu_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            flushed_q  <= flushed_d;
            sdr_req_q  <= sdr_req_d;
            sdr_addr_q <= sdr_addr_d;
            cpu_ok_q   <= cpu_ok_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    // Line payload carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[idx] <= bus.sdr_dout;
            tag_q[idx]  <= tag;
        end
    end

    assign bus.sdr_req  = sdr_req_q;
    assign bus.sdr_addr = sdr_addr_q;
    assign bus.cpu_ok   = cpu_ok_q;
    assign bus.cpu_dout = cpu_dout_q;
endmodule

// File: tb/tb_sdr_fetch_cache.sv
// Directed bench for sdr_fetch_cache with a scoreboard of expected CPU bytes.
module tb_sdr_fetch_cache;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdr_fetch_cache_if bus();
    sdr_fetch_cache_if bus2();

    sdr_fetch_cache #(.INDEX_BITS(6), .ADDR_BASE(25'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    sdr_fetch_cache #(.INDEX_BITS(6), .ADDR_BASE(25'h1FFFFFE)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int fills    = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a read, play the SDRAM channel (rdy after wt cycles of sdr_req), check the result.
    task automatic do_read(input string nm, input logic [16:0] a, input logic [7:0] eb,
                           input int wt, input bit miss, input logic [24:0] sa,
                           input logic [15:0] rd);
        int lat  = 0;
        int held = 0;
        bit seen = 1'b0;
        bus.cpu_cs   = 1'b1;
        bus.cpu_addr = a;
        exp_q.push_back(eb);
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            bus.sdr_rdy = 1'b0;
            if (bus.cpu_ok) break;
            if (bus.sdr_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    fills++;
                    chk({nm, "_sdr_addr"}, 32'(bus.sdr_addr), 32'(sa));
                end
                if (held == wt) begin
                    bus.sdr_rdy  = 1'b1;
                    bus.sdr_dout = rd;
                end
                held++;
            end
        end
        chk({nm, "_ok"}, 32'(bus.cpu_ok), 32'd1);
        chk({nm, "_miss"}, 32'(seen), 32'(miss));
        chk({nm, "_latency"}, 32'(lat), miss ? 32'(3 + wt) : 32'd2);
        if (miss) chk({nm, "_req_held"}, 32'(held), 32'(wt + 1));
        chk({nm, "_req_drop"}, 32'(bus.sdr_req), 32'd0);
        chk({nm, "_dout"}, 32'(bus.cpu_dout), 32'(exp_q.pop_front()));
        bus.cpu_cs = 1'b0;
        @(negedge clk);
        chk({nm, "_ok_drop"}, 32'(bus.cpu_ok), 32'd0);
    endtask

    task automatic flush_idle();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        @(negedge clk);
    endtask

    // Start a fill, assert flush 'early' cycles before sdr_rdy, confirm the word is dropped.
    task automatic flush_fill(input string nm, input logic [16:0] a, input int early,
                              input logic [7:0] eb);
        int n = 0;
        bus.cpu_cs   = 1'b1;
        bus.cpu_addr = a;
        while (!bus.sdr_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k <= 4; k++) begin
            chk({nm, "_req_held"}, 32'(bus.sdr_req), 32'd1);
            bus.flush    = (k == 4 - early);
            bus.sdr_rdy  = (k == 4);
            bus.sdr_dout = 16'hDEAD;
            if (k == 4) bus.cpu_cs = 1'b0;
            @(negedge clk);
        end
        bus.flush   = 1'b0;
        bus.sdr_rdy = 1'b0;
        repeat (3) begin
            chk({nm, "_ok_low"}, 32'(bus.cpu_ok), 32'd0);
            chk({nm, "_req_low"}, 32'(bus.sdr_req), 32'd0);
            @(negedge clk);
        end
        do_read({nm, "_refetch"}, a, eb, 1, 1'b1, {8'd0, a[16:1], 1'b0}, 16'h4321);
    endtask

    initial begin
        int n;
        int f0;
        reset = 1'b1;
        bus.cpu_cs = 1'b0;  bus.cpu_addr = '0;  bus.flush = 1'b0;
        bus.sdr_rdy = 1'b0; bus.sdr_dout = '0;
        bus2.cpu_cs = 1'b0; bus2.cpu_addr = '0; bus2.flush = 1'b0;
        bus2.sdr_rdy = 1'b0; bus2.sdr_dout = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sdr_req",  32'(bus.sdr_req),  32'd0);
        chk("rst_sdr_addr", 32'(bus.sdr_addr), 32'd0);
        chk("rst_cpu_ok",   32'(bus.cpu_ok),   32'd0);
        chk("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
        chk("rst_wrap_req", 32'(bus2.sdr_req), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Base offset wraps modulo 2^25.
        bus2.cpu_cs   = 1'b1;
        bus2.cpu_addr = 17'h00004;
        exp_q.push_back(8'hC3);
        n = 0;
        while (!bus2.sdr_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_sdr_addr", 32'(bus2.sdr_addr), 32'h0000002);
        bus2.sdr_rdy  = 1'b1;
        bus2.sdr_dout = 16'hA5C3;
        @(negedge clk);
        bus2.sdr_rdy = 1'b0;
        chk("wrap_ok",   32'(bus2.cpu_ok),   32'd1);
        chk("wrap_dout", 32'(bus2.cpu_dout), 32'(exp_q.pop_front()));
        bus2.cpu_cs = 1'b0;
        @(negedge clk);

        do_read("cold_miss", 17'h00041, 8'hBE, 5, 1'b1, 25'h000040, 16'hBEEF);
        do_read("hit",       17'h00040, 8'hEF, 0, 1'b0, 25'h0,      16'h0);

        flush_idle();
        f0 = fills;
        do_read("conf_a", 17'h00040, 8'h34, 2, 1'b1, 25'h000040, 16'h1234);
        do_read("conf_b", 17'h00840, 8'h78, 0, 1'b1, 25'h000840, 16'h5678);
        do_read("conf_c", 17'h00040, 8'hBC, 3, 1'b1, 25'h000040, 16'h9ABC);
        chk("conflict_fills", 32'(fills - f0), 32'd3);
        do_read("conf_hit", 17'h00041, 8'h9A, 0, 1'b0, 25'h0, 16'h0);

        flush_fill("flush_early", 17'h00100, 2, 8'h21);
        flush_fill("flush_same",  17'h00181, 0, 8'h43);

        // Reset in the middle of a fill.
        bus.cpu_cs   = 1'b1;
        bus.cpu_addr = 17'h00200;
        n = 0;
        while (!bus.sdr_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rf_req_before", 32'(bus.sdr_req), 32'd1);
        #2 reset = 1'b1;
        #1 chk("rf_req_async", 32'(bus.sdr_req), 32'd0);
        bus.cpu_cs = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.sdr_rdy  = 1'b1;
        bus.sdr_dout = 16'hFACE;
        @(negedge clk);
        bus.sdr_rdy = 1'b0;
        chk("rf_stray_ok",  32'(bus.cpu_ok),  32'd0);
        chk("rf_stray_req", 32'(bus.sdr_req), 32'd0);
        @(negedge clk);
        do_read("rf_reread", 17'h00200, 8'h77, 0, 1'b1, 25'h000200, 16'h1177);
        do_read("rf_cleared", 17'h00041, 8'h24, 1, 1'b1, 25'h000040, 16'h2468);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
